// File: rtl/vault_pkg.sv
// vault_pkg
//   Constants shared by the vault entry conditioner, the lock FSM and the
//   display driver.
//   DIGIT_W                  code digit width (equals the switch bank width)
//   DEBOUNCE_CYCLES_DEFAULT  10 ms of settling time at 100 MHz
//   DEBOUNCE_CYCLES_SIM      short settling time for simulation builds
//   SYNC_STAGES_DEFAULT      synchroniser depth for asynchronous board inputs
package vault_pkg;

  localparam int unsigned DIGIT_W                 = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_SIM     = 4;
  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;

endpackage

// File: rtl/vault_debounce.sv
// vault_debounce
//   Single-bit synchroniser plus debouncer. A level change on the synchronised
//   input must persist for DEBOUNCE_CYCLES consecutive cycles before it is
//   reflected on 'stable'. Any return to the current stable level restarts
//   the count.
// Ports
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   din       in   raw asynchronous input
//   din_sync  out  din after SYNC_STAGES flops
//   stable    out  debounced level
module vault_debounce
  import vault_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic din_sync,
  output logic stable
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;

  assign din_sync = sync_q[SYNC_STAGES-1];
  assign stable   = stable_q;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (din_sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = din_sync;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/vault_entry_conditioner.sv
// vault_entry_conditioner
//   Input stage for the vault lock FSM. Debounces the enter button, samples
//   the code switches on each clean press and offers the digit over a
//   valid/ready handshake. A press arriving while a digit is still pending is
//   dropped and recorded in the sticky overrun flag.
// Ports
//   clk          in   system clock
//   btnC         in   synchronous active-high reset
//   btnU         in   raw enter button
//   sw           in   raw code switches
//   digit        out  captured digit, meaningful while digit_valid=1
//   digit_valid  out  digit pending for the lock FSM
//   digit_ready  in   lock FSM accepts the pending digit this cycle
//   btn_stable   out  debounced btnU level
//   overrun      out  sticky dropped-press flag, cleared by reset only
module vault_entry_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = vault_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = vault_pkg::SYNC_STAGES_DEFAULT,
  parameter int unsigned DIGIT_W         = vault_pkg::DIGIT_W
) (
  input  logic               clk,
  input  logic               btnC,
  input  logic               btnU,
  input  logic [DIGIT_W-1:0] sw,
  output logic [DIGIT_W-1:0] digit,
  output logic               digit_valid,
  input  logic               digit_ready,
  output logic               btn_stable,
  output logic               overrun
);

  logic                            btn_sync;
  logic                            btn_stable_int;
  logic [SYNC_STAGES-1:0][DIGIT_W-1:0] sw_pipe_q, sw_pipe_d;
  logic [DIGIT_W-1:0]              sw_sync;
  logic                            btn_stable_prev_q, btn_stable_prev_d;
  logic [SYNC_STAGES-1:0]          prime_q, prime_d;
  logic                            armed_q, armed_d;
  logic                            press;
  logic [DIGIT_W-1:0]              digit_q, digit_d;
  logic                            digit_valid_q, digit_valid_d;
  logic                            overrun_q, overrun_d;

  vault_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_btn_debounce (
    .clk      (clk),
    .rst      (btnC),
    .din      (btnU),
    .din_sync (btn_sync),
    .stable   (btn_stable_int)
  );

  assign sw_sync     = sw_pipe_q[SYNC_STAGES-1];
  assign btn_stable  = btn_stable_int;
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign overrun     = overrun_q;

  always_comb begin
    sw_pipe_d[0] = sw;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sw_pipe_d[i] = sw_pipe_q[i-1];
    end
  end

  // A button held through reset must not count as a press. Presses are only
  // armed once the synchroniser has filled with post-reset samples and has
  // delivered a released (0) level at least once.
  always_comb begin
    prime_d           = {prime_q[SYNC_STAGES-2:0], 1'b1};
    armed_d           = armed_q | (prime_q[SYNC_STAGES-1] & ~btn_sync);
    btn_stable_prev_d = btn_stable_int;
  end

  assign press = btn_stable_int & ~btn_stable_prev_q & armed_q;

  always_comb begin
    digit_d       = digit_q;
    digit_valid_d = digit_valid_q;
    overrun_d     = overrun_q;
    if (press) begin
      if (!digit_valid_q || digit_ready) begin
        digit_d       = sw_sync;
        digit_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (digit_valid_q && digit_ready) begin
      digit_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      sw_pipe_q         <= '0;
      prime_q           <= '0;
      armed_q           <= 1'b0;
      btn_stable_prev_q <= 1'b0;
      digit_q           <= '0;
      digit_valid_q     <= 1'b0;
      overrun_q         <= 1'b0;
    end else begin
      sw_pipe_q         <= sw_pipe_d;
      prime_q           <= prime_d;
      armed_q           <= armed_d;
      btn_stable_prev_q <= btn_stable_prev_d;
      digit_q           <= digit_d;
      digit_valid_q     <= digit_valid_d;
      overrun_q         <= overrun_d;
    end
  end

endmodule

// File: tb/tb_vault_entry_conditioner.sv
module tb_vault_entry_conditioner;

  localparam int DC = 4;
  localparam int SS = 2;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          btnC, btnU, digit_ready;
  logic [DW-1:0] sw;
  logic [DW-1:0] digit;
  logic          digit_valid, btn_stable, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vault_entry_conditioner #(
    .DEBOUNCE_CYCLES (DC),
    .SYNC_STAGES     (SS),
    .DIGIT_W         (DW)
  ) dut (
    .clk         (clk),
    .btnC        (btnC),
    .btnU        (btnU),
    .sw          (sw),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .btn_stable  (btn_stable),
    .overrun     (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge-indexed history of sampled inputs. The button level
  // seen by the debouncer at edge n is the btnU sample taken SS edges earlier;
  // the debounced level flips when the last DC seen samples all differ from it
  // and none of them precede the previous flip.
  bit            model_ok = 1'b0;
  int            m_n, m_last_flip, m_rise;
  bit            m_stable, m_armed, m_valid, m_over;
  logic [DW-1:0] m_digit;
  bit            hist_b[$];
  logic [DW-1:0] hist_s[$];

  function automatic bit seen_b(int k);
    return (k >= SS) ? hist_b[k-SS] : 1'b0;
  endfunction

  always @(posedge clk) begin
    bit m_press, flip;
    int ws;
    if (btnC) begin
      model_ok    = 1'b1;
      m_n         = 0;
      m_last_flip = 0;
      m_rise      = -100;
      m_stable    = 1'b0;
      m_armed     = 1'b0;
      m_valid     = 1'b0;
      m_over      = 1'b0;
      m_digit     = '0;
      hist_b.delete();
      hist_s.delete();
      hist_b.push_back(1'b0);
      hist_s.push_back('0);
    end else if (model_ok) begin
      m_n++;
      m_press = m_stable && (m_rise == m_n - 1) && m_armed;
      if (m_press) begin
        if (!m_valid || digit_ready) begin
          m_valid = 1'b1;
          m_digit = hist_s[m_n-SS];
        end else begin
          m_over = 1'b1;
        end
      end else if (m_valid && digit_ready) begin
        m_valid = 1'b0;
      end
      ws   = m_n - DC + 1;
      flip = (ws >= 1) && (ws > m_last_flip);
      if (flip) begin
        for (int k = ws; k <= m_n; k++) begin
          if (seen_b(k) == m_stable) flip = 1'b0;
        end
      end
      if (flip) begin
        m_stable    = !m_stable;
        m_last_flip = m_n;
        if (m_stable) m_rise = m_n;
      end
      if ((m_n - SS >= 1) && (hist_b[m_n-SS] == 1'b0)) m_armed = 1'b1;
      hist_b.push_back(btnU);
      hist_s.push_back(sw);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_valid", digit_valid, m_valid);
      check("model_overrun", overrun, m_over);
      check("model_stable", btn_stable, m_stable);
      if (m_valid) check("model_digit", digit, m_digit);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_measure(output int lat);
    lat  = -1;
    btnU = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      if (digit_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_btn();
    btnU = 1'b0;
    cyc(10);
  endtask

  task automatic transfer();
    digit_ready = 1'b1;
    cyc(1);
    digit_ready = 1'b0;
  endtask

  typedef struct {
    logic [DW-1:0] sw_in;
    logic [DW-1:0] exp_digit;
    int            exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit saw;
    int bounce[5];
    int hold;

    vecs[0] = '{4'hB, 4'hB, 7};
    vecs[1] = '{4'h0, 4'h0, 7};
    vecs[2] = '{4'h5, 4'h5, 7};
    vecs[3] = '{4'hA, 4'hA, 7};
    vecs[4] = '{4'hF, 4'hF, 7};
    bounce  = '{1, 0, 1, 1, 0};

    // Reset with the button held, and the button kept held afterwards.
    btnC = 1'b1; btnU = 1'b1; sw = '0; digit_ready = 1'b0;
    cyc(2);
    check("rst_valid", digit_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_stable", btn_stable, 0);
    check("rst_digit", digit, 0);
    btnC = 1'b0;
    saw  = 1'b0;
    repeat (20) begin
      cyc(1);
      if (digit_valid) saw = 1'b1;
    end
    check("held_after_reset", saw, 0);
    release_btn();

    // Clean presses from the vector table.
    foreach (vecs[i]) begin
      sw = vecs[i].sw_in;
      cyc(3);
      press_measure(lat);
      check("clean_latency", lat, vecs[i].exp_lat);
      check("clean_digit", digit, vecs[i].exp_digit);
      cyc(2);
      check("clean_hold_digit", digit, vecs[i].exp_digit);
      transfer();
      check("clean_after_xfer", digit_valid, 0);
      release_btn();
    end

    // Bounce then steady press: one digit, latency from the last rise.
    sw = 4'h7;
    cyc(3);
    foreach (bounce[i]) begin
      btnU = bounce[i][0];
      cyc(1);
    end
    press_measure(lat);
    check("bounce_latency", lat, 7);
    check("bounce_digit", digit, 4'h7);
    transfer();
    saw = 1'b0;
    repeat (15) begin
      cyc(1);
      if (digit_valid) saw = 1'b1;
    end
    check("bounce_single", saw, 0);
    release_btn();
    saw = 1'b0;
    repeat (3) begin
      btnU = 1'b1;
      cyc(3);
      if (digit_valid) saw = 1'b1;
      btnU = 1'b0;
      cyc(3);
      if (digit_valid) saw = 1'b1;
    end
    repeat (10) begin
      cyc(1);
      if (digit_valid) saw = 1'b1;
    end
    check("short_pulses", saw, 0);

    // Overrun: second press while the first digit is pending.
    sw = 4'hF;
    cyc(3);
    press_measure(lat);
    check("ovr_first_latency", lat, 7);
    release_btn();
    sw = 4'h1;
    cyc(3);
    btnU = 1'b1;
    cyc(10);
    check("ovr_digit_kept", digit, 4'hF);
    check("ovr_flag", overrun, 1);
    check("ovr_valid", digit_valid, 1);
    release_btn();
    transfer();
    check("ovr_sticky", overrun, 1);
    check("ovr_xfer_valid", digit_valid, 0);
    btnC = 1'b1;
    cyc(1);
    btnC = 1'b0;
    check("ovr_cleared", overrun, 0);
    cyc(5);

    // Back-to-back: transfer on the same edge as the next press loads.
    sw = 4'hF;
    cyc(3);
    press_measure(lat);
    check("b2b_first_latency", lat, 7);
    release_btn();
    sw = 4'h2;
    cyc(3);
    btnU = 1'b1;
    cyc(6);
    check("b2b_before_digit", digit, 4'hF);
    check("b2b_before_valid", digit_valid, 1);
    digit_ready = 1'b1;
    cyc(1);
    digit_ready = 1'b0;
    check("b2b_valid", digit_valid, 1);
    check("b2b_digit", digit, 4'h2);
    check("b2b_overrun", overrun, 0);
    transfer();
    release_btn();

    // Reset mid-debounce with a digit pending.
    sw = 4'h3;
    cyc(3);
    press_measure(lat);
    release_btn();
    btnU = 1'b1;
    cyc(3);
    btnC = 1'b1;
    cyc(1);
    check("midrst_valid", digit_valid, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_stable", btn_stable, 0);
    check("midrst_digit", digit, 0);
    btnC = 1'b0;
    btnU = 1'b0;
    cyc(5);
    sw = 4'h6;
    cyc(3);
    press_measure(lat);
    check("midrst_latency", lat, 7);
    check("midrst_new_digit", digit, 4'h6);
    transfer();
    release_btn();

    // Randomised traffic, checked continuously against the model.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        btnU = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 9) == 0) sw = DW'($urandom);
      digit_ready = ($urandom_range(0, 3) == 0);
      btnC        = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    btnC = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
